// File: rtl/udp_loopback_buffer.sv
// udp_loopback_buffer
//   Single-clock byte buffer between the UDP receive and transmit sides of
//   eth_if. Received payload words are queued in a dual-port RAM and released
//   to the transmit side as bursts whose length is latched when the burst
//   starts (capped at MAX_PAYLOAD). A burst is launched on a full payload's
//   worth of data, on a datagram end (rx_last), or optionally on idle timeout.
//
//   Optional feature: define UDPBUF_TIMEOUT_EN to enable the idle timer that
//   flushes a partial payload after TIMEOUT_CYCLES idle cycles.
//
// Ports:
//   clk             system clock, rising edge
//   rst_n           asynchronous active-low reset
//   rx_data/rx_dv   received payload word and its valid
//   rx_last         final word of a datagram (qualified by rx_dv)
//   tx_valid        burst offered; tx_pending_data valid and stable
//   tx_pending_data latched burst length
//   tx_rden         pop one word
//   tx_data         popped word, registered, valid 1 cycle after tx_rden
//   rd_data_count   words currently stored
//   full            buffer holds 2**DEPTH_LOG2 words
//   drop_count      words dropped on overflow (saturating)
//   protocol_err    sticky: tx_rden outside a burst
module udp_loopback_buffer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned DEPTH_LOG2     = 11,
  parameter int unsigned LEN_WIDTH      = 16,
  parameter int unsigned MAX_PAYLOAD    = 1472,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_dv,
  input  logic                  rx_last,
  output logic                  tx_valid,
  output logic [LEN_WIDTH-1:0]  tx_pending_data,
  input  logic                  tx_rden,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic [LEN_WIDTH-1:0]  rd_data_count,
  output logic                  full,
  output logic [LEN_WIDTH-1:0]  drop_count,
  output logic                  protocol_err
);

  localparam int unsigned CW = DEPTH_LOG2 + 1;
  localparam logic [CW-1:0] DEPTH_W = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [CW-1:0] MAX_W   = CW'(MAX_PAYLOAD);

  typedef enum logic {
    IDLE,
    SENDING
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]         count, remaining, launch_len;
  logic                  full_i, wr_en, rd_en, launch, flush_pending, timeout_hit;

  assign full_i     = (count == DEPTH_W);
  assign wr_en      = rx_dv && !full_i;
  // A pop is only honoured inside a burst that still has words left.
  assign rd_en      = (state == SENDING) && tx_rden && (remaining != '0);
  // Registered count only: a write landing in the launch cycle joins the next burst.
  assign launch_len = (count < MAX_W) ? count : MAX_W;

  assign tx_valid      = (state == SENDING);
  assign full          = full_i;
  assign rd_data_count = LEN_WIDTH'(count);

`ifdef UDPBUF_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] timer;

  // Counts idle cycles with data waiting and nothing arriving.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state != IDLE || wr_en || launch) begin
      timer <= '0;
    end else if (count != '0) begin
      timer <= timer + 1'b1;
    end
  end

  assign timeout_hit = (state == IDLE) && (count != '0) && (timer == TMO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      IDLE: begin
        if ((count >= MAX_W) || (flush_pending && count != '0) || timeout_hit) begin
          launch    = 1'b1;
          state_nxt = SENDING;
        end
      end
      SENDING: begin
        if ((rd_en && remaining == CW'(1)) || remaining == '0) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage array has no reset; stale contents are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wptr] <= rx_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr            <= '0;
      rptr            <= '0;
      count           <= '0;
      remaining       <= '0;
      flush_pending   <= 1'b0;
      tx_pending_data <= '0;
      tx_data         <= '0;
      drop_count      <= '0;
      protocol_err    <= 1'b0;
    end else begin
      if (wr_en) begin
        wptr <= wptr + 1'b1;
      end
      if (rd_en) begin
        rptr    <= rptr + 1'b1;
        tx_data <= mem[rptr];
      end

      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      if (launch) begin
        remaining <= launch_len;
      end else if (rd_en) begin
        remaining <= remaining - 1'b1;
      end

      if (launch) begin
        tx_pending_data <= LEN_WIDTH'(launch_len);
      end else if (state == SENDING && state_nxt == IDLE) begin
        tx_pending_data <= '0;
      end

      // Set has priority over the launch-time clear so a datagram end
      // arriving in the launch cycle still triggers the following burst.
      if (rx_dv && rx_last) begin
        flush_pending <= 1'b1;
      end else if (launch) begin
        flush_pending <= 1'b0;
      end

      if (rx_dv && full_i && drop_count != '1) begin
        drop_count <= drop_count + 1'b1;
      end

      if (tx_rden && !rd_en) begin
        protocol_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_udp_loopback_buffer.sv
// Self-checking bench for udp_loopback_buffer: a behavioural model tracks the
// stored words as a queue; stimulus pushes the expected burst lengths, and a
// monitor compares every cycle's outputs against the model.
module tb_udp_loopback_buffer;

  localparam int unsigned DEPTH = 2048;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_dv = 1'b0;
  logic        rx_last = 1'b0;
  logic        tx_rden = 1'b0;
  logic        tx_valid;
  logic [15:0] tx_pending_data;
  logic [7:0]  tx_data;
  logic [15:0] rd_data_count;
  logic        full;
  logic [15:0] drop_count;
  logic        protocol_err;

  always #5 clk = ~clk;

  udp_loopback_buffer #(
    .DATA_WIDTH    (8),
    .DEPTH_LOG2    (11),
    .LEN_WIDTH     (16),
    .MAX_PAYLOAD   (1472),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rx_data        (rx_data),
    .rx_dv          (rx_dv),
    .rx_last        (rx_last),
    .tx_valid       (tx_valid),
    .tx_pending_data(tx_pending_data),
    .tx_rden        (tx_rden),
    .tx_data        (tx_data),
    .rd_data_count  (rd_data_count),
    .full           (full),
    .drop_count     (drop_count),
    .protocol_err   (protocol_err)
  );

  int unsigned n_chk = 0;
  int unsigned n_pass = 0;

  // Reference model state
  int unsigned exp_len_q[$];
  logic [7:0]  exp_data_q[$];
  int unsigned m_count = 0;
  int unsigned m_drop = 0;
  logic        m_perr = 1'b0;
  logic [7:0]  exp_tx = '0;
  int unsigned pop_total = 0;
  int unsigned m_underflow = 0;

  // Monitor burst tracking
  bit          in_burst = 1'b0;
  int unsigned cur_len = 0;
  int unsigned burst_pops = 0;
  int unsigned pop_seen = 0;

  // Reader control
  bit          force_rden = 1'b0;
  int unsigned rd_target = 32'hFFFF_FFFF;
  int unsigned rd_issued = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Model: sampled at the active edge with pre-edge values.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_count = 0;
      m_drop  = 0;
      m_perr  = 1'b0;
      exp_tx  = '0;
      exp_data_q.delete();
    end else begin
      if (tx_rden && tx_valid) begin
        if (exp_data_q.size() == 0) m_underflow++;
        else begin
          exp_tx = exp_data_q.pop_front();
          m_count--;
        end
        pop_total++;
      end else if (tx_rden) begin
        m_perr = 1'b1;
      end
      if (rx_dv) begin
        if (m_count < DEPTH) begin
          exp_data_q.push_back(rx_data);
          m_count++;
        end else if (m_drop < 65535) begin
          m_drop++;
        end
      end
    end
  end

  // Monitor: compares outputs half a cycle after each active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      in_burst = 1'b0;
      pop_seen = pop_total;
    end else begin
      chk("rd_data_count", rd_data_count, m_count);
      chk("full", full, (m_count == DEPTH));
      chk("drop_count", drop_count, m_drop);
      chk("protocol_err", protocol_err, m_perr);
      chk("tx_data", tx_data, exp_tx);
      chk("pop_underflow", m_underflow, 0);
      burst_pops += pop_total - pop_seen;
      pop_seen = pop_total;
      if (tx_valid) begin
        if (!in_burst) begin
          in_burst   = 1'b1;
          burst_pops = 0;
          if (exp_len_q.size() == 0) begin
            n_chk++;
            $display("FAIL unexpected_burst: got len %0d expected no burst at %0t", tx_pending_data, $time);
            cur_len = tx_pending_data;
          end else begin
            cur_len = exp_len_q.pop_front();
            chk("burst_len", tx_pending_data, cur_len);
          end
        end else begin
          chk("len_stable", tx_pending_data, cur_len);
        end
      end else begin
        if (in_burst) begin
          chk("burst_pops", burst_pops, cur_len);
          in_burst = 1'b0;
        end
        chk("len_idle_zero", tx_pending_data, 0);
      end
    end
  end

  // Reader: pops while a burst is offered and the pop budget allows.
  always @(negedge clk) begin
    if (tx_valid && rd_issued < rd_target) begin
      tx_rden = 1'b1;
      rd_issued++;
    end else begin
      tx_rden = force_rden;
    end
  end

  task automatic wr(input logic [7:0] d, input logic last);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_data = d;
    rx_last = last;
  endtask

  task automatic wr_end();
    @(negedge clk);
    rx_dv   = 1'b0;
    rx_last = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int unsigned max);
    int unsigned k = 0;
    while ((exp_len_q.size() != 0 || tx_valid || in_burst) && k < max) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk({nm, "_drain_in_time"}, (k < max), 1);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_tx_valid"}, tx_valid, 0);
    chk({nm, "_tx_pending_data"}, tx_pending_data, 0);
    chk({nm, "_tx_data"}, tx_data, 0);
    chk({nm, "_rd_data_count"}, rd_data_count, 0);
    chk({nm, "_full"}, full, 0);
    chk({nm, "_drop_count"}, drop_count, 0);
    chk({nm, "_protocol_err"}, protocol_err, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1: 100-word datagram, data 0..99
    exp_len_q.push_back(100);
    for (int i = 0; i < 100; i++) wr(8'(i), (i == 99));
    wr_end();
    #1 chk("t1_valid_not_yet", tx_valid, 0);
    @(negedge clk);
    #1 chk("t1_valid_latency", tx_valid, 1);
    wait_drain("t1", 500);
    chk("t1_protocol_err", protocol_err, 0);

    // 2: 3000-word stream without rx_last
    exp_len_q.push_back(1472);
    exp_len_q.push_back(1472);
`ifdef UDPBUF_TIMEOUT_EN
    exp_len_q.push_back(56);
`endif
    for (int i = 0; i < 3000; i++) wr(8'($urandom), 1'b0);
    wr_end();
    wait_drain("t2", 8000);
`ifndef UDPBUF_TIMEOUT_EN
    repeat (20) @(negedge clk);
    #1 chk("t2_residue", rd_data_count, 56);
    exp_len_q.push_back(57);
    wr(8'($urandom), 1'b1);
    wr_end();
    wait_drain("t2_flush", 500);
`endif

    // 3: overflow
    rd_target = rd_issued;
    exp_len_q.push_back(1472);
    for (int i = 0; i < DEPTH + 5; i++) wr(8'($urandom), 1'b0);
    wr_end();
    #1;
    chk("t3_full", full, 1);
    chk("t3_drop_count", drop_count, 5);
    chk("t3_rd_data_count", rd_data_count, DEPTH);
    rd_target = 32'hFFFF_FFFF;
    wait_drain("t3", 3000);
    exp_len_q.push_back(577);
    wr(8'($urandom), 1'b1);
    wr_end();
    wait_drain("t3_flush", 1500);

    // 4: concurrent write/pop across pointer wrap
    exp_len_q.push_back(1472);
    exp_len_q.push_back(1472);
    exp_len_q.push_back(29);
    for (int i = 0; i < 2973; i++) wr(8'($urandom), (i == 2972));
    wr_end();
    wait_drain("t4", 8000);
    chk("t4_empty", rd_data_count, 0);

    // 5: tx_rden in IDLE
    @(negedge clk);
    #1 force_rden = 1'b1;
    @(negedge clk);
    #1 force_rden = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("t5_protocol_err_set", protocol_err, 1);
    chk("t5_count_unchanged", rd_data_count, 0);

    // 6: reset mid-burst
    rd_target = rd_issued;
    exp_len_q.push_back(50);
    for (int i = 0; i < 50; i++) wr(8'($urandom), (i == 49));
    wr_end();
    for (int k = 0; k < 20 && !tx_valid; k++) @(negedge clk);
    chk("t6_burst_started", tx_valid, 1);
    rd_target = rd_issued + 10;
    repeat (14) @(negedge clk);
    #1 chk("t6_mid_burst_count", rd_data_count, 40);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("t6_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    rd_target = 32'hFFFF_FFFF;
    exp_len_q.push_back(20);
    for (int i = 0; i < 20; i++) wr(8'($urandom), (i == 19));
    wr_end();
    wait_drain("t6", 500);

    repeat (5) @(negedge clk);
    chk("final_data_queue_empty", exp_data_q.size(), 0);
    chk("final_len_queue_empty", exp_len_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
